stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 stall_i  input  1  downstream (stage_id side) cannot accept; output register holds.
REQ-004 branch_flag_i  input  1  one-cycle redirect request from execute (mispredict or jalr).
REQ-005 branch_target_i  input  32  redirect PC, valid with branch_flag_i.
REQ-006 mem_req_o  output  1  instruction fetch request to memory controller.
REQ-007 mem_addr_o  output  32  fetch address; stable while mem_req_o=1 until accepted.
REQ-008 mem_ready_i  input  1  one-cycle pulse: mem_inst_i valid, request completed.
REQ-009 mem_inst_i  input  32  fetched instruction word.
REQ-010 valid_o  output  1  pc_o/inst_o hold a real instruction (0 = bubble).
REQ-011 pc_o  output  32  PC of inst_o.
REQ-012 inst_o  output  32  instruction to decode.
REQ-013 predict_result_o  output  1  1 = predicted taken.
REQ-014 npc_o  output  32  predicted next PC for inst_o.

Function
REQ-015 FSM states: FETCH (request outstanding), DROP (stale request outstanding, result discarded), HOLD (fetched word buffered, waiting on stall_i).
REQ-016 Registers: pc (next fetch PC), req_addr (address on mem_addr_o), one-entry buffer {pc, inst, pred, npc}, output register.
REQ-017 mem_req_o = 1 in FETCH and DROP, 0 in HOLD; mem_addr_o = req_addr.
REQ-018 req_addr changes only on an edge where mem_req_o=0 or mem_ready_i=1.
REQ-019 Prediction, combinational on mem_inst_i: opcode 1101111 (jal) -> taken, npc = pc + J-imm; opcode 1100011 with inst[31]=1 (backward branch) -> taken, npc = pc + B-imm; else not taken, npc = pc + 4; 32-bit wrap-around add, immediates sign-extended.
REQ-020 FETCH, mem_ready_i=1, stall_i=0: output register <= {1, req_addr, mem_inst_i, pred, npc}; pc and req_addr <= npc; stay FETCH (back-to-back, one instruction per ready pulse).
REQ-021 FETCH, mem_ready_i=1, stall_i=1: word goes to buffer; pc <= npc; -> HOLD; output register unchanged.
REQ-022 HOLD, stall_i=0: output register <= buffer; req_addr <= pc; -> FETCH.
REQ-023 Any edge with stall_i=0 and no word delivered: valid_o <= 0, other outputs hold value.
REQ-024 stall_i=1: output register holds all fields, including valid_o.
REQ-025 Redirect (branch_flag_i=1) has priority over stall_i and mem_ready_i: valid_o <= 0; buffer discarded; pc <= branch_target_i.
REQ-026 Redirect in FETCH with mem_ready_i=1, or in HOLD: req_addr <= branch_target_i; -> FETCH.
REQ-027 Redirect in FETCH with mem_ready_i=0: -> DROP; req_addr unchanged.
REQ-028 Redirect in DROP: pc updated only; stay DROP.
REQ-029 DROP, mem_ready_i=1, no redirect: word discarded; req_addr <= pc; -> FETCH.
REQ-030 No instruction fetched before a redirect reaches valid_o=1 after it.

Reset
REQ-031 rst_n=0 asynchronously: state FETCH, pc=0, req_addr=0, buffer cleared, valid_o=0, pc_o=0, inst_o=0, predict_result_o=0, npc_o=0.
REQ-032 First edge after release: mem_req_o=1, mem_addr_o=0; reset mid-request abandons it; a ready pulse in the reset cycle is ignored.

Verification
REQ-033 Reset release, ready every cycle, words 0x00000013 -> addresses 0,4,8 issued; valid_o=1 with pc_o=0,4,8 one edge after each ready; predict_result_o=0, npc_o=pc_o+4.
REQ-034 Word 0x0080006F (jal +8) at pc 0x10 -> predict_result_o=1, npc_o=0x18; next mem_addr_o=0x18.
REQ-035 Word 0xFE000EE3 (beq -4) at pc 0x20 -> predict_result_o=1, npc_o=0x1C.
REQ-036 stall_i=1 for 3 cycles as ready arrives for pc 0x8 -> outputs frozen, mem_req_o=0 while in HOLD; after release valid_o=1, pc_o=0x8, fetch of 0xC resumes.
REQ-037 branch_flag_i=1, target 0x100, while ready pending for 0x40; ready two cycles later -> that word never reaches inst_o; next mem_addr_o=0x100; valid_o=0 until 0x100 returns.
REQ-038 rst_n asserted mid-request and in HOLD -> all outputs zero immediately; restart fetch at 0.

Source files
------------

// File: rtl/stage_if_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory controller.
// mem_addr is held stable while mem_req is high until mem_ready pulses.
interface stage_if_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_inst;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_inst
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_inst
  );
endinterface

// File: rtl/stage_if.sv
// Instruction fetch stage with static branch prediction (jal / backward branch taken), a one-entry
// stall buffer, and discard of in-flight fetches made stale by an execute-stage redirect.
module stage_if (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  stage_if_if.master        mem_bus,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              predict_result_o,
  output logic [31:0]       npc_o
);

  typedef enum logic [1:0] {StFetch, StDrop, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;

  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic        buf_pred_q;
  logic [31:0] buf_npc_q;

  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_inst_q;
  logic        out_pred_q;
  logic [31:0] out_npc_q;

  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        pred_taken;
  logic [31:0] pred_npc;

  assign mem_bus.mem_req  = (state_q != StHold);
  assign mem_bus.mem_addr = req_addr_q;

  assign valid_o          = out_valid_q;
  assign pc_o             = out_pc_q;
  assign inst_o           = out_inst_q;
  assign predict_result_o = out_pred_q;
  assign npc_o            = out_npc_q;

  // In StFetch pc_q always equals req_addr_q, so the returning word belongs to req_addr_q.
  assign opcode = mem_bus.mem_inst[6:0];
  assign j_imm  = {{12{mem_bus.mem_inst[31]}}, mem_bus.mem_inst[19:12], mem_bus.mem_inst[20],
                   mem_bus.mem_inst[30:21], 1'b0};
  assign b_imm  = {{20{mem_bus.mem_inst[31]}}, mem_bus.mem_inst[7], mem_bus.mem_inst[30:25],
                   mem_bus.mem_inst[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_npc   = req_addr_q + 32'd4;
    if (opcode == 7'b1101111) begin
      pred_taken = 1'b1;
      pred_npc   = req_addr_q + j_imm;
    end else if (opcode == 7'b1100011 && mem_bus.mem_inst[31]) begin
      pred_taken = 1'b1;
      pred_npc   = req_addr_q + b_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      req_addr_q  <= '0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
      buf_pred_q  <= 1'b0;
      buf_npc_q   <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_pred_q  <= 1'b0;
      out_npc_q   <= '0;
    end else if (branch_flag_i) begin
      out_valid_q <= 1'b0;
      pc_q        <= branch_target_i;
      unique case (state_q)
        StFetch: begin
          // A request still outstanding must complete before the address may move.
          if (mem_bus.mem_ready) begin
            req_addr_q <= branch_target_i;
            state_q    <= StFetch;
          end else begin
            state_q    <= StDrop;
          end
        end
        StHold: begin
          req_addr_q <= branch_target_i;
          state_q    <= StFetch;
        end
        StDrop: state_q <= StDrop;
        default: state_q <= StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_bus.mem_ready) begin
            pc_q <= pred_npc;
            if (!stall_i) begin
              out_valid_q <= 1'b1;
              out_pc_q    <= req_addr_q;
              out_inst_q  <= mem_bus.mem_inst;
              out_pred_q  <= pred_taken;
              out_npc_q   <= pred_npc;
              req_addr_q  <= pred_npc;
            end else begin
              buf_pc_q    <= req_addr_q;
              buf_inst_q  <= mem_bus.mem_inst;
              buf_pred_q  <= pred_taken;
              buf_npc_q   <= pred_npc;
              state_q     <= StHold;
            end
          end else if (!stall_i) begin
            out_valid_q <= 1'b0;
          end
        end
        StHold: begin
          if (!stall_i) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= buf_pc_q;
            out_inst_q  <= buf_inst_q;
            out_pred_q  <= buf_pred_q;
            out_npc_q   <= buf_npc_q;
            req_addr_q  <= pc_q;
            state_q     <= StFetch;
          end
        end
        StDrop: begin
          if (!stall_i) begin
            out_valid_q <= 1'b0;
          end
          if (mem_bus.mem_ready) begin
            req_addr_q <= pc_q;
            state_q    <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: straight-line fetch, prediction, stall/hold, redirect with stale
// fetch discard, and asynchronous reset in the middle of a request and in HOLD.
module tb_stage_if;
  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        predict_result_o;
  logic [31:0] npc_o;

  int tests;
  int fails;

  stage_if_if mem_bus ();

  stage_if dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .mem_bus          (mem_bus),
    .valid_o          (valid_o),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .predict_result_o (predict_result_o),
    .npc_o            (npc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic pred, input logic [31:0] npc);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".inst"}, inst_o, inst);
    chk({tag, ".pred"}, {31'd0, predict_result_o}, {31'd0, pred});
    chk({tag, ".npc"}, npc_o, npc);
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, mem_bus.mem_req}, {31'd0, req});
    chk({tag, ".addr"}, mem_bus.mem_addr, addr);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_inst = '0;

    // Reset state, with a ready pulse during reset that must be ignored
    #3;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_inst = 32'h0000_0013;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("reset_ready_ignored", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    chk_mem("after_release", 1'b1, 32'h0);

    // Back-to-back nops at 0, 4, 8
    step();
    chk_out("seq0", 1'b1, 32'h0, 32'h13, 1'b0, 32'h4);
    chk_mem("seq0", 1'b1, 32'h4);
    step();
    chk_out("seq4", 1'b1, 32'h4, 32'h13, 1'b0, 32'h8);
    chk_mem("seq4", 1'b1, 32'h8);
    step();
    chk_out("seq8", 1'b1, 32'h8, 32'h13, 1'b0, 32'hC);
    chk_mem("seq8", 1'b1, 32'hC);
    mem_bus.mem_ready = 1'b0;
    step();
    chk_out("bubble", 1'b0, 32'h8, 32'h13, 1'b0, 32'hC);
    chk_mem("bubble", 1'b1, 32'hC);

    // jal +8 at 0x10
    mem_bus.mem_ready = 1'b1;
    step();
    chk_out("seqC", 1'b1, 32'hC, 32'h13, 1'b0, 32'h10);
    mem_bus.mem_inst = 32'h0080_006F;
    step();
    chk_out("jal", 1'b1, 32'h10, 32'h0080_006F, 1'b1, 32'h18);
    chk_mem("jal", 1'b1, 32'h18);

    // Redirect to 0x20 while 0x18 outstanding: stale word dropped
    mem_bus.mem_ready = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h20;
    step();
    chk_out("redir20", 1'b0, 32'h10, 32'h0080_006F, 1'b1, 32'h18);
    chk_mem("redir20", 1'b1, 32'h18);
    branch_flag_i = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_inst = 32'hDEAD_BEEF;
    step();
    chk_out("drop18", 1'b0, 32'h10, 32'h0080_006F, 1'b1, 32'h18);
    chk_mem("drop18", 1'b1, 32'h20);
    mem_bus.mem_inst = 32'hFE00_0EE3;
    step();
    chk_out("beq", 1'b1, 32'h20, 32'hFE00_0EE3, 1'b1, 32'h1C);
    chk_mem("beq", 1'b1, 32'h1C);

    // Redirect to 0x8, then stall 3 cycles as its word arrives
    mem_bus.mem_ready = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h8;
    step();
    branch_flag_i = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_inst = 32'hDEAD_BEEF;
    step();
    chk_mem("redir8", 1'b1, 32'h8);
    mem_bus.mem_inst = 32'h0000_0013;
    stall_i = 1'b1;
    step();
    chk_out("hold1", 1'b0, 32'h20, 32'hFE00_0EE3, 1'b1, 32'h1C);
    chk_mem("hold1", 1'b0, 32'h8);
    mem_bus.mem_ready = 1'b0;
    step();
    chk_mem("hold2", 1'b0, 32'h8);
    step();
    chk_out("hold3", 1'b0, 32'h20, 32'hFE00_0EE3, 1'b1, 32'h1C);
    stall_i = 1'b0;
    step();
    chk_out("unhold", 1'b1, 32'h8, 32'h13, 1'b0, 32'hC);
    chk_mem("unhold", 1'b1, 32'hC);
    stall_i = 1'b1;
    step();
    chk_out("stall_keep_valid", 1'b1, 32'h8, 32'h13, 1'b0, 32'hC);
    stall_i = 1'b0;

    // Redirect to 0x40 with ready (immediate), then to 0x100 while 0x40 pending
    branch_flag_i = 1'b1;
    branch_target_i = 32'h40;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_inst = 32'hDEAD_BEEF;
    step();
    chk_out("redir40", 1'b0, 32'h8, 32'h13, 1'b0, 32'hC);
    chk_mem("redir40", 1'b1, 32'h40);
    mem_bus.mem_ready = 1'b0;
    branch_target_i = 32'h100;
    step();
    chk_mem("redir100", 1'b1, 32'h40);
    branch_flag_i = 1'b0;
    step();
    chk_mem("drop_wait", 1'b1, 32'h40);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_inst = 32'h1111_1113;
    step();
    chk_out("drop40", 1'b0, 32'h8, 32'h13, 1'b0, 32'hC);
    chk_mem("drop40", 1'b1, 32'h100);
    mem_bus.mem_inst = 32'h0000_0013;
    step();
    chk_out("got100", 1'b1, 32'h100, 32'h13, 1'b0, 32'h104);

    // Redirect while in HOLD beats the stall
    stall_i = 1'b1;
    step();
    chk_mem("hold104", 1'b0, 32'h104);
    mem_bus.mem_ready = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_flag_i = 1'b0;
    chk_out("redir_hold", 1'b0, 32'h100, 32'h13, 1'b0, 32'h104);
    chk_mem("redir_hold", 1'b1, 32'h200);

    // Reset in HOLD: outputs clear without a clock edge
    mem_bus.mem_ready = 1'b1;
    step();
    chk_mem("hold200", 1'b0, 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_hold", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk_mem("rst_hold", 1'b1, 32'h0);
    stall_i = 1'b0;
    step();
    rst_n = 1'b1;
    mem_bus.mem_ready = 1'b0;
    step();
    chk_out("restart_idle", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk_mem("restart_idle", 1'b1, 32'h0);
    mem_bus.mem_ready = 1'b1;
    step();
    chk_out("restart0", 1'b1, 32'h0, 32'h13, 1'b0, 32'h4);
    mem_bus.mem_ready = 1'b0;
    step();
    chk_mem("pending4", 1'b1, 32'h4);

    // Reset mid-request
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk_mem("rst_mid", 1'b1, 32'h0);
    step();
    rst_n = 1'b1;
    mem_bus.mem_ready = 1'b1;
    step();
    chk_out("restart_mid", 1'b1, 32'h0, 32'h13, 1'b0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
